// File: rtl/data_sram_responder_if.sv
// data_sram_responder_if: req/addr_ok/data_ok data-SRAM port between CPU (master) and memory (slave)
interface data_sram_responder_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  modport master(output req, wr, size, addr, wdata, input addr_ok, data_ok, rdata);
  modport slave(input req, wr, size, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/data_sram_responder.sv
// data_sram_responder: data-SRAM responder, fixed-latency in-order responses; DSRAM_STALL_EN adds LFSR addr_ok stalls
module data_sram_responder #(
  parameter int ADDR_WIDTH      = 10,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic clk,
  input logic resetn,
  data_sram_responder_if.slave sram
);
  logic [31:0] mem [0:2**ADDR_WIDTH-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic [3:0] be;
  logic [31:0] wd;
  logic run, stall, accept;
  logic [3:0] count;
  logic [LATENCY-1:0] vld, ld;
  logic [31:0] word [LATENCY];
  logic unused_addr;
  assign idx = sram.addr[ADDR_WIDTH+1:2];
  assign unused_addr = ^sram.addr[31:ADDR_WIDTH+2];
`ifdef DSRAM_STALL_EN
  logic [7:0] lfsr;
  // Fibonacci LFSR (taps 8,6,5,4) free-runs to inject pseudo-random accept stalls
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lfsr <= 8'hA5;
    else lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign stall = &lfsr[1:0];
`else
  assign stall = 1'b0;
`endif
  // Sub-word stores replicate the low byte/half so any lane picks up the right data
  always_comb begin
    be = sram.size == 2'd0 ? 4'b0001 << sram.addr[1:0] :
         sram.size == 2'd1 ? (sram.addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = sram.size == 2'd0 ? {4{sram.wdata[7:0]}} :
         sram.size == 2'd1 ? {2{sram.wdata[15:0]}} : sram.wdata;
  end
  assign sram.addr_ok = run && count != 4'(MAX_OUTSTANDING) && !stall;
  assign accept = sram.req && sram.addr_ok;
  assign sram.data_ok = vld[LATENCY-1];
  assign sram.rdata = vld[LATENCY-1] && ld[LATENCY-1] ? word[LATENCY-1] : 32'd0;
  // Array is deliberately not reset so contents survive a mid-run reset
  always_ff @(posedge clk)
    if (accept && sram.wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  // Response delay line and in-flight count; run holds addr_ok low for the first cycle out of reset
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      run <= 1'b0;
      count <= '0;
      vld <= '0;
      ld <= '0;
      for (int i = 0; i < LATENCY; i++) word[i] <= '0;
    end else begin
      run <= 1'b1;
      count <= count + 4'(accept) - 4'(vld[LATENCY-1]);
      vld[0] <= accept;
      ld[0] <= accept && !sram.wr;
      word[0] <= accept && !sram.wr ? mem[idx] : 32'd0;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        ld[i] <= ld[i-1];
        word[i] <= word[i-1];
      end
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: scoreboard bench for data_sram_responder (LATENCY 2 and LATENCY 4 instances)
module tb_data_sram_responder;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  typedef struct {int due; logic [31:0] data;} exp_t;
  exp_t sb[$];
  int acc_q[$];
  logic [31:0] model [0:1023];
  data_sram_responder_if a();
  data_sram_responder_if b();
  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .MAX_OUTSTANDING(2)) dut_a (.clk(clk), .resetn(resetn), .sram(a));
  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(4), .MAX_OUTSTANDING(2)) dut_b (.clk(clk), .resetn(resetn), .sram(b));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
`ifdef DSRAM_STALL_EN
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge resetn)
    if (!resetn) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  function automatic bit stall_m();
    return m_lfsr[1:0] == 2'b11;
  endfunction
`else
  function automatic bit stall_m();
    return 1'b0;
  endfunction
`endif
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic exp_aok();
    while (acc_q.size() != 0 && acc_q[0] + 2 < cyc) void'(acc_q.pop_front());
    return acc_q.size() != 2 && !stall_m();
  endfunction
  always @(negedge clk)
    if (resetn) begin
      if (a.data_ok) begin
        exp_t e;
        if (sb.size() == 0) chk("spurious data_ok", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("data_ok cycle", cyc, e.due);
          chk("rdata", a.rdata, e.data);
        end
      end else chk("rdata idle", a.rdata, 32'd0);
    end
  task automatic op(bit w, logic [1:0] s, logic [31:0] ad, logic [31:0] d);
    int n = 0;
    logic [31:0] e;
    a.req = 1'b1; a.wr = w; a.size = s; a.addr = ad; a.wdata = d;
    chk("addr_ok", a.addr_ok, exp_aok());
    while (!a.addr_ok && n < 64) begin
      @(negedge clk);
      n++;
      chk("addr_ok", a.addr_ok, exp_aok());
    end
    if (!a.addr_ok) chk("accept timeout", 32'd0, 32'd1);
    else begin
      e = 32'd0;
      if (w) begin
        if (s == 2'd0) model[ad[11:2]][8*ad[1:0] +: 8] = d[7:0];
        else if (s == 2'd1) model[ad[11:2]][16*ad[1] +: 16] = d[15:0];
        else model[ad[11:2]] = d;
      end else e = model[ad[11:2]];
      acc_q.push_back(cyc);
      sb.push_back('{cyc + 2, e});
    end
    @(negedge clk);
    a.req = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [11:0] aok_e, dok_e;
    int acc;
    a.req = 1'b1; a.wr = 1'b0; a.size = 2'd2; a.addr = 32'h0; a.wdata = 32'h0;
    b.req = 1'b0; b.wr = 1'b0; b.size = 2'd2; b.addr = 32'h0; b.wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset addr_ok", a.addr_ok, 32'd0);
    chk("reset data_ok", a.data_ok, 32'd0);
    chk("reset rdata", a.rdata, 32'd0);
    resetn = 1'b1;
    chk("release addr_ok", a.addr_ok, 32'd0);
    @(negedge clk);
    a.req = 1'b0;
    chk("post-reset addr_ok", a.addr_ok, exp_aok());
    chk("post-reset addr_ok b", b.addr_ok, 32'd1);
    op(1'b1, 2'd2, 32'h10, 32'h12345678);
    op(1'b0, 2'd2, 32'h10, 32'h0);
    repeat (3) @(negedge clk);
    op(1'b1, 2'd0, 32'h13, 32'h000000AB);
    op(1'b0, 2'd2, 32'h10, 32'h0);
    op(1'b1, 2'd1, 32'h12, 32'h0000CDEF);
    op(1'b0, 2'd2, 32'h10, 32'h0);
    op(1'b1, 2'd1, 32'h13, 32'h00001357);
    op(1'b0, 2'd2, 32'h10, 32'h0);
    repeat (4) @(negedge clk);
`ifndef DSRAM_STALL_EN
    aok_e = 12'b110001100011;
    dok_e = 12'b011000110000;
    acc = 0;
    b.req = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (acc == 4) b.req = 1'b0;
      chk($sformatf("b addr_ok c%0d", k), b.addr_ok, aok_e[k]);
      chk($sformatf("b data_ok c%0d", k), b.data_ok, dok_e[k]);
      if (b.req && b.addr_ok) acc++;
      @(negedge clk);
    end
    b.req = 1'b0;
    chk("b accept count", acc, 32'd4);
`endif
    op(1'b0, 2'd2, 32'h10, 32'h0);
    resetn = 1'b0;
    sb.delete();
    acc_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("data_ok in reset", a.data_ok, 32'd0);
    end
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("data_ok after reset", a.data_ok, 32'd0);
    end
    op(1'b0, 2'd2, 32'h10, 32'h0);
    for (int i = 0; i < 16; i++) op(1'b1, 2'd2, 32'h100 + 32'(i * 4), $urandom);
    for (int i = 0; i < 200; i++) begin
      op(1'(($urandom_range(0, 1))), 2'($urandom_range(0, 3)),
         (32'h100 + 32'($urandom_range(0, 63))) | ($urandom & 32'hFFFF_F000), $urandom);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("scoreboard drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
